div_seq: RTL and testbench

Iterative signed 32-bit divider for the multicycle MIPS core, implementing `div rs, rt`. It sits directly upstream of the HI/LO registers: it consumes operands A and B and returns quotient on `lo` and remainder on `hi`. It handshakes with the control unit through `start`/`ready` and flags division by zero on `div_zero` for the exception path.

---
 rtl/div_seq.sv | 136 +++++++++++++
 tb/tb_div_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative signed divider for the multicycle MIPS core (div rs, rt).
// Restoring division on operand magnitudes, one quotient bit per clock, with
// the signs applied in a final fix-up cycle. The quotient goes to lo and the
// remainder to hi. A zero divisor is reported on div_zero without touching
// hi or lo.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;        // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_r;        // partial remainder, always < |b| between iterations
  logic [WIDTH-1:0] r_abs_b;
  logic [CW-1:0]    r_count;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_ready;
  logic             r_div_zero;
  logic             r_busy;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_r_shift;  // one extra bit: the shifted remainder can reach 2*|b|-1
  logic [WIDTH:0]   w_r_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_shift;

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign ready    = r_ready;
  assign div_zero = r_div_zero;
  assign busy     = r_busy;

  // Operand magnitudes and the trial subtraction for the current iteration.
  // Negating 0x80000000 yields 0x80000000, which is its correct unsigned magnitude.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    w_abs_a   = a[WIDTH-1] ? -a : a;
    w_abs_b   = b[WIDTH-1] ? -b : b;
    w_r_shift = {r_r, r_q[WIDTH-1]};
    w_r_diff  = w_r_shift - {1'b0, r_abs_b};
    w_ge      = (w_r_shift >= {1'b0, r_abs_b});
    w_q_shift = {r_q[WIDTH-2:0], 1'b0};
  end

  // Control FSM and datapath; every output is a register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      // NOTE: the datapath registers are cleared too, so no stale operand survives a mid-operation reset.
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_r        <= '0;
      r_abs_b    <= '0;
      r_count    <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_ready    <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (b == '0) begin
              r_div_zero <= 1'b1;
              r_ready    <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_q        <= w_abs_a;
              r_abs_b    <= w_abs_b;
              r_sa       <= a[WIDTH-1];
              r_sb       <= b[WIDTH-1];
              r_r        <= '0;
              r_count    <= '0;
              r_div_zero <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_CALC: begin
          // The restored remainder is below |b|, so it fits back into WIDTH bits.
          r_r     <= w_ge ? w_r_diff[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
          r_q     <= {w_q_shift[WIDTH-1:1], w_ge};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // Quotient truncates toward zero; remainder takes the dividend's sign.
          r_lo    <= (r_sa ^ r_sb) ? -r_q : r_q;
          r_hi    <= r_sa ? -r_r : r_r;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq. Expected results come from
// 64-bit signed arithmetic on the operands; latency, pulse shape and the
// div_zero/hold behaviour are checked against fixed expectations.
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        div_zero;
  logic        busy;

  int n_checks;
  int n_errors;

  // expected state of the outputs after the operation in flight
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_dz;
  int          exp_lat;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ready    (ready),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed division truncating toward zero, evaluated in 64 bits
  // so that 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r);
    longint sx;
    longint sy;
    longint lq;
    longint lr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lq = sx / sy;
    lr = sx % sy;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // Drive one start pulse from a negedge; returns one negedge later with
  // the operand lines scrambled so only latched copies can matter.
  task automatic pulse_start(input logic [31:0] ta, input logic [31:0] tb_v);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    if (tb_v == 32'h0) begin
      exp_dz  = 1'b1;
      exp_lat = 1;
    end else begin
      model(ta, tb_v, exp_lo, exp_hi);
      exp_dz  = 1'b0;
      exp_lat = 34;
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait (bounded) for ready and check the result. glitch > 0 pulses an
  // ignored start with a=1,b=1 at that cycle of the operation.
  task automatic wait_result(input string tag, input int glitch);
    int cycles;
    cycles = 1;
    if (exp_lat == 34) begin
      check({tag, "_busy_early"}, {31'b0, busy}, 32'd1);
      check({tag, "_dz_clear"}, {31'b0, div_zero}, 32'd0);
    end
    while (!ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cycles == glitch) begin
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_dz"}, {31'b0, div_zero}, {31'b0, exp_dz});
    check({tag, "_busy_rdy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input int glitch);
    pulse_start(ta, tb_v);
    wait_result(tag, glitch);
    @(negedge clk);
    check({tag, "_rdy_pulse"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hi"}, hi, 32'h0);
    check({tag, "_lo"}, lo, 32'h0);
    check({tag, "_ready"}, {31'b0, ready}, 32'd0);
    check({tag, "_dz"}, {31'b0, div_zero}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    exp_hi   = 32'h0;
    exp_lo   = 32'h0;
    exp_dz   = 1'b0;
    exp_lat  = 34;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");

    // directed sign and corner cases
    run_op("d100_7", 32'd100, 32'd7, 0);
    run_op("dm7_2", 32'hFFFF_FFF9, 32'd2, 0);
    run_op("d7_m2", 32'd7, 32'hFFFF_FFFE, 0);
    run_op("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("dmin_1", 32'h8000_0000, 32'd1, 0);

    // divide by zero keeps hi/lo; next valid start clears div_zero
    run_op("z100_7", 32'd100, 32'd7, 0);
    run_op("z5_0", 32'd5, 32'd0, 0);
    run_op("zclr", 32'd21, 32'd5, 0);

    // start while busy is ignored
    run_op("ign", 32'd100, 32'd7, 5);

    // reset in the middle of an operation
    pulse_start(32'd50, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    reset  = 1'b0;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    @(negedge clk);
    run_op("post_rst", 32'd9, 32'd3, 0);

    // back-to-back: new start presented in the ready cycle
    pulse_start(32'd100, 32'd7);
    wait_result("b2b_first", 0);
    pulse_start(32'hFFFF_FFF7, 32'd4);
    wait_result("b2b_second", 0);
    @(negedge clk);
    check("b2b_rdy_pulse", {31'b0, ready}, 32'd0);

    // back-to-back divide by zero: ready stays up, hi/lo untouched
    pulse_start(32'd3, 32'd0);
    wait_result("b2bz_first", 0);
    pulse_start(32'd4, 32'd0);
    wait_result("b2bz_second", 0);
    @(negedge clk);

    // randomized operands with assorted divisor sizes
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op("rand", ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // absolute guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
